// File: rtl/dm_bus_ctrl_if.sv
// Requester-side data-space bus of dm_bus_ctrl: logical address, strobes and write data in;
// read data, completion, busy and error status back.
interface dm_bus_ctrl_if;
   logic [15:0] mm_addr;
   logic        mm_re;
   logic        mm_we;
   logic [7:0]  mm_wdata;
   logic [7:0]  mm_rdata;
   logic        mm_ack;
   logic        mm_busy;
   logic        mm_err;

   modport master (
      output mm_addr, mm_re, mm_we, mm_wdata,
      input  mm_rdata, mm_ack, mm_busy, mm_err
   );

   modport slave (
      input  mm_addr, mm_re, mm_we, mm_wdata,
      output mm_rdata, mm_ack, mm_busy, mm_err
   );
endinterface

// File: rtl/dm_bus_ctrl.sv
// Data-space bus controller: decodes a 16-bit logical address into unmapped / I/O / SRAM /
// external regions and runs one access at a time with registered device strobes.
module dm_bus_ctrl #(
   parameter logic [15:0] IO_BASE   = 16'h0020,
   parameter logic [15:0] SRAM_BASE = 16'h0100,
   parameter int unsigned DM_AW     = 11,
   parameter int unsigned EXT_WAIT  = 2
) (
   input  logic             clk,
   input  logic             rst,
   dm_bus_ctrl_if.slave     mm,
   output logic [DM_AW-1:0] dm_addr,
   output logic             dm_re,
   output logic             dm_we,
   output logic [7:0]       dm_wdata,
   input  logic [7:0]       dm_rdata,
   output logic [7:0]       io_addr,
   output logic             io_re,
   output logic             io_we,
   output logic [7:0]       io_wdata,
   input  logic [7:0]       io_rdata,
   output logic [15:0]      xm_addr,
   output logic             xm_re,
   output logic             xm_we,
   output logic [7:0]       xm_wdata,
   input  logic [7:0]       xm_rdata
);

   // 17 bits so an SRAM ending exactly at 64 KiB leaves the external region empty.
   localparam logic [16:0] SramLimit = {1'b0, SRAM_BASE} + (17'd1 << DM_AW);
   localparam logic [15:0] XmBase    = SramLimit[15:0];
   localparam logic [3:0]  WaitLast  = 4'(EXT_WAIT);

   typedef enum logic [1:0] {StIdle, StAcc, StXwait, StResp} state_e;
   typedef enum logic [1:0] {RgnNone, RgnIo, RgnDm, RgnXm} rgn_e;

   state_e           state_q, state_d;
   rgn_e             src_q, src_d;
   rgn_e             rgn;
   logic [3:0]       cnt_q, cnt_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic [7:0]       xrdata_q, xrdata_d;

   logic [DM_AW-1:0] dm_addr_q, dm_addr_d;
   logic             dm_re_q, dm_re_d;
   logic             dm_we_q, dm_we_d;
   logic [7:0]       dm_wdata_q, dm_wdata_d;
   logic [7:0]       io_addr_q, io_addr_d;
   logic             io_re_q, io_re_d;
   logic             io_we_q, io_we_d;
   logic [7:0]       io_wdata_q, io_wdata_d;
   logic [15:0]      xm_addr_q, xm_addr_d;
   logic             xm_re_q, xm_re_d;
   logic             xm_we_q, xm_we_d;
   logic [7:0]       xm_wdata_q, xm_wdata_d;

   logic             req;
   logic             wr;
   logic [7:0]       io_off;
   logic [DM_AW-1:0] dm_off;
   logic [15:0]      xm_off;
   logic [7:0]       rdata;

   assign req    = mm.mm_re | mm.mm_we;
   assign wr     = mm.mm_we;
   assign io_off = 8'(mm.mm_addr - IO_BASE);
   assign dm_off = DM_AW'(mm.mm_addr - SRAM_BASE);
   assign xm_off = mm.mm_addr - XmBase;

   always_comb begin
      if (mm.mm_addr < IO_BASE) begin
         rgn = RgnNone;
      end else if (mm.mm_addr < SRAM_BASE) begin
         rgn = RgnIo;
      end else if ({1'b0, mm.mm_addr} < SramLimit) begin
         rgn = RgnDm;
      end else begin
         rgn = RgnXm;
      end
   end

   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      cnt_d      = cnt_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      xrdata_d   = xrdata_q;
      dm_addr_d  = dm_addr_q;
      dm_re_d    = dm_re_q;
      dm_we_d    = dm_we_q;
      dm_wdata_d = dm_wdata_q;
      io_addr_d  = io_addr_q;
      io_re_d    = io_re_q;
      io_we_d    = io_we_q;
      io_wdata_d = io_wdata_q;
      xm_addr_d  = xm_addr_q;
      xm_re_d    = xm_re_q;
      xm_we_d    = xm_we_q;
      xm_wdata_d = xm_wdata_q;

      unique case (state_q)
         StIdle, StResp: begin
            state_d = StIdle;
            src_d   = RgnNone;
            if (req) begin
               // src records which device supplies read data in RESP; writes return zero.
               unique case (rgn)
                  RgnNone: begin
                     state_d = StResp;
                     ack_d   = 1'b1;
                     err_d   = 1'b1;
                  end
                  RgnIo: begin
                     state_d    = StAcc;
                     io_addr_d  = io_off;
                     io_wdata_d = mm.mm_wdata;
                     io_we_d    = wr;
                     io_re_d    = ~wr;
                     src_d      = wr ? RgnNone : RgnIo;
                  end
                  RgnDm: begin
                     state_d    = StAcc;
                     dm_addr_d  = dm_off;
                     dm_wdata_d = mm.mm_wdata;
                     dm_we_d    = wr;
                     dm_re_d    = ~wr;
                     src_d      = wr ? RgnNone : RgnDm;
                  end
                  RgnXm: begin
                     state_d    = StXwait;
                     cnt_d      = 4'd0;
                     xm_addr_d  = xm_off;
                     xm_wdata_d = mm.mm_wdata;
                     xm_we_d    = wr;
                     xm_re_d    = ~wr;
                     src_d      = wr ? RgnNone : RgnXm;
                  end
                  default: state_d = StIdle;
               endcase
            end
         end
         StAcc: begin
            io_re_d = 1'b0;
            io_we_d = 1'b0;
            dm_re_d = 1'b0;
            dm_we_d = 1'b0;
            state_d = StResp;
            ack_d   = 1'b1;
         end
         StXwait: begin
            if (cnt_q == WaitLast) begin
               xrdata_d = xm_rdata;
               xm_re_d  = 1'b0;
               xm_we_d  = 1'b0;
               cnt_d    = 4'd0;
               state_d  = StResp;
               ack_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         src_q      <= RgnNone;
         cnt_q      <= 4'd0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         xrdata_q   <= 8'h00;
         dm_addr_q  <= '0;
         dm_re_q    <= 1'b0;
         dm_we_q    <= 1'b0;
         dm_wdata_q <= 8'h00;
         io_addr_q  <= 8'h00;
         io_re_q    <= 1'b0;
         io_we_q    <= 1'b0;
         io_wdata_q <= 8'h00;
         xm_addr_q  <= 16'h0000;
         xm_re_q    <= 1'b0;
         xm_we_q    <= 1'b0;
         xm_wdata_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         cnt_q      <= cnt_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         xrdata_q   <= xrdata_d;
         dm_addr_q  <= dm_addr_d;
         dm_re_q    <= dm_re_d;
         dm_we_q    <= dm_we_d;
         dm_wdata_q <= dm_wdata_d;
         io_addr_q  <= io_addr_d;
         io_re_q    <= io_re_d;
         io_we_q    <= io_we_d;
         io_wdata_q <= io_wdata_d;
         xm_addr_q  <= xm_addr_d;
         xm_re_q    <= xm_re_d;
         xm_we_q    <= xm_we_d;
         xm_wdata_q <= xm_wdata_d;
      end
   end

   // I/O and SRAM data is taken live in RESP; external data was captured on the last wait cycle.
   always_comb begin
      rdata = 8'h00;
      if (ack_q) begin
         case (src_q)
            RgnIo:   rdata = io_rdata;
            RgnDm:   rdata = dm_rdata;
            RgnXm:   rdata = xrdata_q;
            default: rdata = 8'h00;
         endcase
      end
   end

   assign mm.mm_rdata = rdata;
   assign mm.mm_ack   = ack_q;
   assign mm.mm_err   = err_q;
   assign mm.mm_busy  = (state_q == StAcc) || (state_q == StXwait);

   assign dm_addr  = dm_addr_q;
   assign dm_re    = dm_re_q;
   assign dm_we    = dm_we_q;
   assign dm_wdata = dm_wdata_q;
   assign io_addr  = io_addr_q;
   assign io_re    = io_re_q;
   assign io_we    = io_we_q;
   assign io_wdata = io_wdata_q;
   assign xm_addr  = xm_addr_q;
   assign xm_re    = xm_re_q;
   assign xm_we    = xm_we_q;
   assign xm_wdata = xm_wdata_q;

   a_strobe_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0({dm_re_q, dm_we_q, io_re_q, io_we_q, xm_re_q, xm_we_q}));
   a_err_with_ack: assert property (@(posedge clk) disable iff (rst) err_q |-> ack_q);
   a_ack_not_busy: assert property (@(posedge clk) disable iff (rst)
      ack_q |-> !((state_q == StAcc) || (state_q == StXwait)));

endmodule
